// File: rtl/axis_fifo_replay_ctrl.sv
// axis_fifo_replay_ctrl
//
// Purpose: sequencer around a non-frame-mode AXI-stream FIFO that has a
// read-pointer-reset input. A start command flushes the FIFO and captures
// exactly one upstream frame. That frame is then replayed downstream
// cfg_count times by rewinding the FIFO read pointer between replays.
// Only the valid/ready handshakes pass through this block. tdata, tkeep and
// tuser are wired directly between upstream, the FIFO and downstream.
//
// Optional feature: define AXIS_REPLAY_GAP_EN to add the cfg_gap port.
// With it, each inter-frame gap lasts max(1, cfg_gap) cycles. Without it,
// each gap lasts exactly one cycle.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_start, cfg_abort   command pulses (start only in IDLE, abort elsewhere)
//   cfg_count              number of replays, latched on an accepted start
//   cfg_gap                inter-frame idle cycles (AXIS_REPLAY_GAP_EN only)
//   s_axis_*               upstream handshake (valid, ready, last)
//   fifo_s_*               FIFO write-side handshake
//   fifo_m_*               FIFO read-side handshake (valid, ready, last)
//   m_axis_*               downstream handshake
//   fifo_rst               registered one-cycle synchronous reset to the FIFO
//   fifo_reset_read_ptr    registered one-cycle read-pointer rewind pulse
//   status_busy            high whenever the sequencer is not IDLE
//   status_done            one-cycle pulse when all replays have completed
//   status_error           one-cycle pulse when the captured frame is too long
//   status_index           number of replays completed so far
module axis_fifo_replay_ctrl #(
  parameter int MAX_BEATS = 4096,
  parameter int CNT_WIDTH = 8,
  parameter int GAP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [CNT_WIDTH-1:0] cfg_count,
`ifdef AXIS_REPLAY_GAP_EN
  input  logic [GAP_WIDTH-1:0] cfg_gap,
`endif
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 fifo_s_tvalid,
  input  logic                 fifo_s_tready,
  input  logic                 fifo_m_tvalid,
  output logic                 fifo_m_tready,
  input  logic                 fifo_m_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 fifo_rst,
  output logic                 fifo_reset_read_ptr,
  output logic                 status_busy,
  output logic                 status_done,
  output logic                 status_error,
  output logic [CNT_WIDTH-1:0] status_index
);

  localparam int BEAT_WIDTH = $clog2(MAX_BEATS) + 1;
  localparam logic [BEAT_WIDTH-1:0] LAST_SLOT = BEAT_WIDTH'(MAX_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CAPTURE,
    DRAIN,
    REPLAY,
    GAP,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  index_q;
  logic [CNT_WIDTH-1:0]  index_inc;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [GAP_WIDTH-1:0]  gap_left;
  logic [GAP_WIDTH-1:0]  gap_load;
  logic                  fifo_rst_q;
  logic                  fifo_rst_n;
  logic                  rptr_rst_q;
  logic                  rptr_rst_n;
  logic                  error_q;
  logic                  error_n;
  logic                  cap_beat;
  logic                  drain_beat;
  logic                  down_beat;

  // Raw handshake qualifiers. They are only meaningful in the state that
  // actually passes the corresponding handshake through.
  assign cap_beat   = s_axis_tvalid & fifo_s_tready;
  assign drain_beat = s_axis_tvalid;
  assign down_beat  = fifo_m_tvalid & m_axis_tready;

  // status_index can never pass count_q, but the increment saturates anyway
  // so that the index can never wrap.
  assign index_inc = (index_q == '1) ? index_q : index_q + 1'b1;

  // The gap counter is loaded with at least 1. The read-pointer pulse is
  // issued in the first gap cycle, so the gap is never shorter than one cycle.
`ifdef AXIS_REPLAY_GAP_EN
  logic [GAP_WIDTH-1:0] gap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else if (state == IDLE && cfg_start) begin
      gap_q <= cfg_gap;
    end
  end

  assign gap_load = (gap_q == '0) ? GAP_WIDTH'(1) : gap_q;
`else
  assign gap_load = GAP_WIDTH'(1);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and the one-cycle pulse requests. An abort in any busy
  // state overrides whatever the normal transition would have been. This
  // guarantees that an abort produces no done or error pulse.
  always_comb begin
    state_n    = state;
    fifo_rst_n = 1'b0;
    rptr_rst_n = 1'b0;
    error_n    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_n    = FLUSH;
          fifo_rst_n = 1'b1;
        end
      end
      FLUSH: begin
        state_n = CAPTURE;
      end
      CAPTURE: begin
        if (cap_beat) begin
          if (s_axis_tlast) begin
            state_n = (count_q != '0) ? REPLAY : DONE;
          end else if (beat_cnt == LAST_SLOT) begin
            state_n = DRAIN;
            error_n = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_beat && s_axis_tlast) begin
          state_n    = IDLE;
          fifo_rst_n = 1'b1;
        end
      end
      REPLAY: begin
        if (down_beat && fifo_m_tlast) begin
          if (index_inc == count_q) begin
            state_n = DONE;
          end else begin
            state_n    = GAP;
            rptr_rst_n = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_left <= GAP_WIDTH'(1)) begin
          state_n = REPLAY;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state != IDLE && cfg_abort) begin
      state_n    = IDLE;
      fifo_rst_n = 1'b1;
      rptr_rst_n = 1'b0;
      error_n    = 1'b0;
    end
  end

  // Registered pulses, configuration and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rst_q <= 1'b0;
      rptr_rst_q <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      index_q    <= '0;
      beat_cnt   <= '0;
      gap_left   <= '0;
    end else begin
      fifo_rst_q <= fifo_rst_n;
      rptr_rst_q <= rptr_rst_n;
      error_q    <= error_n;
      if (state == IDLE && cfg_start) begin
        count_q  <= cfg_count;
        index_q  <= '0;
        beat_cnt <= '0;
      end
      if (state == CAPTURE && cap_beat && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == REPLAY && down_beat && fifo_m_tlast) begin
        index_q <= index_inc;
      end
      if (rptr_rst_n) begin
        gap_left <= gap_load;
      end else if (state == GAP && gap_left != '0) begin
        gap_left <= gap_left - 1'b1;
      end
    end
  end

  // Handshake gating. Each handshake passes through only in the state that
  // owns it. DRAIN accepts and discards upstream beats without writing them
  // to the FIFO.
  always_comb begin
    s_axis_tready = 1'b0;
    fifo_s_tvalid = 1'b0;
    m_axis_tvalid = 1'b0;
    fifo_m_tready = 1'b0;
    case (state)
      CAPTURE: begin
        s_axis_tready = fifo_s_tready;
        fifo_s_tvalid = s_axis_tvalid;
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
      end
      REPLAY: begin
        m_axis_tvalid = fifo_m_tvalid;
        fifo_m_tready = m_axis_tready;
      end
      default: begin
        s_axis_tready = 1'b0;
      end
    endcase
  end

  assign fifo_rst            = fifo_rst_q;
  assign fifo_reset_read_ptr = rptr_rst_q;
  assign status_busy         = (state != IDLE);
  assign status_done         = (state == DONE);
  assign status_error        = error_q;
  assign status_index        = index_q;

endmodule

// File: tb/tb_axis_fifo_replay_ctrl.sv
// tb_axis_fifo_replay_ctrl
//
// Purpose: self-checking bench for axis_fifo_replay_ctrl with MAX_BEATS=16.
// A small FIFO fixture sits between the upstream and downstream sides. It
// holds 8-bit data plus a last flag, and it supports synchronous reset and a
// read-pointer rewind. Expected results come from a frame-level model: the
// downstream output is the captured frame repeated count times, and an
// overlength frame produces an error and no output.
//
// Ports: none (top-level bench). Works with or without AXIS_REPLAY_GAP_EN;
// with the feature enabled, cfg_gap is held at 0.
module tb_axis_fifo_replay_ctrl;

  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int GW    = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int count;
    int len;
    int rmode;
    bit with_abort;
    int exp_beats;
    int exp_done;
    int exp_err;
    int exp_rptr;
    int exp_index;
    int exp_frst;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic          cfg_abort;
  logic [CW-1:0] cfg_count;
`ifdef AXIS_REPLAY_GAP_EN
  logic [GW-1:0] cfg_gap;
`endif
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          fifo_s_tvalid;
  logic          fifo_s_tready;
  logic          fifo_m_tvalid;
  logic          fifo_m_tready;
  logic          fifo_m_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          fifo_rst;
  logic          fifo_reset_read_ptr;
  logic          status_busy;
  logic          status_done;
  logic          status_error;
  logic [CW-1:0] status_index;
  logic [7:0]    up_data;
  logic [7:0]    fifo_m_data;

  axis_fifo_replay_ctrl #(
    .MAX_BEATS(DEPTH),
    .CNT_WIDTH(CW),
    .GAP_WIDTH(GW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_start          (cfg_start),
    .cfg_abort          (cfg_abort),
    .cfg_count          (cfg_count),
`ifdef AXIS_REPLAY_GAP_EN
    .cfg_gap            (cfg_gap),
`endif
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .fifo_s_tvalid      (fifo_s_tvalid),
    .fifo_s_tready      (fifo_s_tready),
    .fifo_m_tvalid      (fifo_m_tvalid),
    .fifo_m_tready      (fifo_m_tready),
    .fifo_m_tlast       (fifo_m_tlast),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .fifo_rst           (fifo_rst),
    .fifo_reset_read_ptr(fifo_reset_read_ptr),
    .status_busy        (status_busy),
    .status_done        (status_done),
    .status_error       (status_error),
    .status_index       (status_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO fixture. The write pointer never wraps, so the captured frame stays
  // in place and a read-pointer rewind replays it from the start.
  logic [7:0] mem_data [DEPTH];
  logic       mem_last [DEPTH];
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;

  assign fifo_s_tready = (wr_ptr < 5'(DEPTH));
  assign fifo_m_tvalid = (rd_ptr < wr_ptr);
  assign fifo_m_data   = fifo_m_tvalid ? mem_data[rd_ptr[3:0]] : 8'h00;
  assign fifo_m_tlast  = fifo_m_tvalid ? mem_last[rd_ptr[3:0]] : 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_s_tvalid && fifo_s_tready) begin
        mem_data[wr_ptr[3:0]] <= up_data;
        mem_last[wr_ptr[3:0]] <= s_axis_tlast;
        wr_ptr <= wr_ptr + 5'd1;
      end
      if (fifo_reset_read_ptr) begin
        rd_ptr <= '0;
      end else if (fifo_m_tvalid && fifo_m_tready) begin
        rd_ptr <= rd_ptr + 5'd1;
      end
    end
  end

  // Bench bookkeeping shared by the tasks.
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  beat_t src_q[$];
  beat_t out_q[$];
  beat_t frame[$];
  int    n_done, n_err, n_rptr, n_frst, n_bad_valid, n_bad_rptr;
  int    up_beats, up_tlast_cyc, done_cyc, err_cyc, beat16_cyc;
  bit    prev_down_tlast;
  bit    last_busy;
  bit    last_mvalid;
  vec_t  vecs[7];

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge. Inputs are driven
  // first, then the settled outputs are sampled. Those sampled outputs are the
  // values the next rising edge acts on.
  task automatic applyStimulus();
    if (src_q.size() > 0) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tlast  = src_q[0].last;
      up_data       = src_q[0].data;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      up_data       = 8'h00;
    end
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc % 2) == 0);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (status_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (status_error) begin
      n_err++;
      err_cyc = cyc;
    end
    if (fifo_rst) n_frst++;
    if (fifo_reset_read_ptr) begin
      n_rptr++;
      if (!prev_down_tlast) n_bad_rptr++;
    end
    if (m_axis_tvalid && (!status_busy || fifo_reset_read_ptr)) n_bad_valid++;
    last_busy   = status_busy;
    last_mvalid = m_axis_tvalid;
    prev_down_tlast = 1'b0;
    if (s_axis_tvalid && s_axis_tready) begin
      up_beats++;
      if (up_beats == DEPTH) beat16_cyc = cyc;
      if (s_axis_tlast) up_tlast_cyc = cyc;
      void'(src_q.pop_front());
    end
    if (m_axis_tvalid && m_axis_tready) begin
      out_q.push_back('{data: fifo_m_data, last: fifo_m_tlast});
      prev_down_tlast = fifo_m_tlast;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Clears the bookkeeping, builds a random frame and issues the start cycle.
  task automatic startRun(input int count, input int len, input int rmode, input bit with_abort);
    beat_t b;
    frame.delete();
    src_q.delete();
    out_q.delete();
    n_done = 0; n_err = 0; n_rptr = 0; n_frst = 0; n_bad_valid = 0; n_bad_rptr = 0;
    up_beats = 0; up_tlast_cyc = -1; done_cyc = -1; err_cyc = -1; beat16_cyc = -100;
    prev_down_tlast = 1'b0;
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.last = (i == len - 1);
      frame.push_back(b);
      src_q.push_back(b);
    end
    ready_mode = rmode;
    cfg_count  = CW'(count);
    cfg_start  = 1'b1;
    cfg_abort  = with_abort;
    applyStimulus();
    cfg_start  = 1'b0;
    cfg_abort  = 1'b0;
  endtask

  // Frame-level reference: a frame that fits is replayed count times; a
  // longer one is rejected with no output and an extra FIFO reset.
  function automatic vec_t modelExpect(input int count, input int len, input int rmode);
    vec_t v;
    v.count = count;
    v.len = len;
    v.rmode = rmode;
    v.with_abort = 1'b0;
    if (len > DEPTH) begin
      v.exp_beats = 0; v.exp_done = 0; v.exp_err = 1;
      v.exp_rptr = 0; v.exp_index = 0; v.exp_frst = 2;
    end else begin
      v.exp_beats = count * len; v.exp_done = 1; v.exp_err = 0;
      v.exp_rptr = (count > 0) ? count - 1 : 0; v.exp_index = count; v.exp_frst = 1;
    end
    return v;
  endfunction

  task automatic runScenario(input vec_t v, input string tag);
    bit finished;
    bit stray_sent;
    int mism;
    int n;
    startRun(v.count, v.len, v.rmode, v.with_abort);
    finished = 1'b0;
    stray_sent = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (v.count >= 2 && !stray_sent && out_q.size() == 1) begin
        cfg_start  = 1'b1;
        cfg_count  = 8'd9;
        stray_sent = 1'b1;
      end
      applyStimulus();
      cfg_start = 1'b0;
      if (!last_busy) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput({tag, "/finished"}, int'(finished), 1);
    checkOutput({tag, "/beats"}, out_q.size(), v.exp_beats);
    mism = 0;
    n = (out_q.size() < v.exp_beats) ? out_q.size() : v.exp_beats;
    for (int i = 0; i < n; i++) begin
      if (out_q[i] != frame[i % v.len]) mism++;
    end
    checkOutput({tag, "/data"}, mism, 0);
    checkOutput({tag, "/done"}, n_done, v.exp_done);
    checkOutput({tag, "/error"}, n_err, v.exp_err);
    checkOutput({tag, "/rptr"}, n_rptr, v.exp_rptr);
    checkOutput({tag, "/index"}, int'(status_index), v.exp_index);
    checkOutput({tag, "/fifo_rst"}, n_frst, v.exp_frst);
    checkOutput({tag, "/valid_outside"}, n_bad_valid, 0);
    checkOutput({tag, "/rptr_timing"}, n_bad_rptr, 0);
    checkOutput({tag, "/upstream_left"}, src_q.size(), 0);
    if (v.exp_err == 0 && v.count == 0) checkOutput({tag, "/done_latency"}, done_cyc - up_tlast_cyc, 1);
    if (v.exp_err != 0) checkOutput({tag, "/error_beat"}, err_cyc - beat16_cyc, 1);
  endtask

  initial begin
    bit reached;
    vec_t rv;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_count = '0;
`ifdef AXIS_REPLAY_GAP_EN
    cfg_gap = '0;
`endif
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    up_data = 8'h00;
    m_axis_tready = 1'b0;

    // Vectors: count, len, ready mode, abort-with-start, then expected
    // beats, done, error, rptr pulses, final index, fifo_rst pulses.
    vecs[0] = '{3, 4, 0, 1'b0, 12, 1, 0, 2, 3, 1};
    vecs[1] = '{0, 4, 0, 1'b0, 0, 1, 0, 0, 0, 1};
    vecs[2] = '{1, 20, 0, 1'b0, 0, 0, 1, 0, 0, 2};
    vecs[3] = '{2, 5, 1, 1'b0, 10, 1, 0, 1, 2, 1};
    vecs[4] = '{1, 16, 2, 1'b0, 16, 1, 0, 0, 1, 1};
    vecs[5] = '{2, 1, 2, 1'b1, 2, 1, 0, 1, 2, 1};
    vecs[6] = '{255, 1, 0, 1'b0, 255, 1, 0, 254, 255, 1};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset/busy", int'(status_busy), 0);
    checkOutput("reset/pulses", int'({status_done, status_error, fifo_rst, fifo_reset_read_ptr}), 0);
    checkOutput("reset/index", int'(status_index), 0);
    checkOutput("reset/handshakes", int'({s_axis_tready, fifo_s_tvalid, m_axis_tvalid, fifo_m_tready}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      runScenario(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rv = modelExpect($urandom_range(0, 5), $urandom_range(1, 20), 2);
      runScenario(rv, $sformatf("rand%0d", i));
    end

    // Abort one beat into the second replay.
    startRun(3, 4, 0, 1'b0);
    reached = 1'b0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus();
      if (out_q.size() == 5) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("abort/reach_second_replay", int'(reached), 1);
    cfg_abort = 1'b1;
    applyStimulus();
    cfg_abort = 1'b0;
    applyStimulus();
    checkOutput("abort/busy_next_cycle", int'(last_busy), 0);
    checkOutput("abort/fifo_rst", n_frst, 2);
    checkOutput("abort/m_valid", int'(last_mvalid), 0);
    repeat (3) applyStimulus();
    checkOutput("abort/no_done", n_done, 0);
    checkOutput("abort/beats", out_q.size(), 6);
    checkOutput("abort/index", int'(status_index), 1);

    // Asynchronous reset in the middle of a replay.
    startRun(3, 4, 0, 1'b0);
    reached = 1'b0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus();
      if (out_q.size() == 2) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("rst/reach_replay", int'(reached), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst/busy", int'(status_busy), 0);
    checkOutput("rst/fifo_rst", int'(fifo_rst), 0);
    checkOutput("rst/index", int'(status_index), 0);
    checkOutput("rst/m_valid", int'(m_axis_tvalid), 0);
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    @(negedge clk);

    // Recovery after the asynchronous reset.
    runScenario(modelExpect(2, 3, 0), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
